// File: rtl/pipe_engine_if.sv
`default_nettype none
// ============================================================================
// pipe_engine_if
//   Game-side bundle between the bird controller / test harness and the pipe
//   engine: run request and bird row in, pipe playfield, game over and score out.
//   Rev 1.0 - initial release
// ============================================================================
interface pipe_engine_if;
  logic            enable;
  logic [7:0]      bird_row;
  logic [7:0][7:0] red_array;
  logic            game_over;
  logic [7:0]      score;

  modport master (
    output enable,
    output bird_row,
    input  red_array,
    input  game_over,
    input  score
  );

  modport slave (
    input  enable,
    input  bird_row,
    output red_array,
    output game_over,
    output score
  );
endinterface
`default_nettype wire

// File: rtl/pipe_engine.sv
`default_nettype none
// ============================================================================
// pipe_engine
//   Scrolling-pipe playfield for an 8x8 flappy-bird style game: pipe injection,
//   LFSR gap placement, column-0 collision detection and saturating score.
//   Rev 1.0 - initial release
// ============================================================================
module pipe_engine #(
  parameter int SCROLL_PERIOD = 25000000,
  parameter int PIPE_SPACING  = 4
) (
  input  wire logic    clock,
  input  wire logic    reset,
  pipe_engine_if.slave bus
);

  localparam int c_TICK_W = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;
  localparam int c_SPC_W  = (PIPE_SPACING  > 1) ? $clog2(PIPE_SPACING)  : 1;

  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SCROLL_PERIOD - 1);
  localparam logic [c_SPC_W-1:0]  c_SPC_LAST  = c_SPC_W'(PIPE_SPACING - 1);
  localparam logic [7:0]          c_LFSR_SEED = 8'hA5;
  localparam logic [2:0]          c_GAP_MAX   = 3'd5;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_OVER = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;

  logic [7:0][7:0]     r_red_array;
  logic [7:0]          r_score;
  logic                r_game_over;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic [c_SPC_W-1:0]  r_spc_cnt;
  logic [7:0]          r_lfsr;

  logic                w_collide;
  logic                w_start;
  logic                w_clear;
  logic                w_advance;
  logic                w_tick;
  logic [2:0]          w_gap;
  logic [7:0]          w_pipe;
  logic [7:0]          w_new_col;
  logic                w_lfsr_fb;

  // Collision only matters while running; the FSM ignores it elsewhere.
  assign w_collide = |(r_red_array[0] & bus.bird_row);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (bus.enable) begin
          w_state_next = c_RUN;
        end
      end
      c_RUN: begin
        if (!bus.enable) begin
          w_state_next = c_IDLE;
        end else if (w_collide) begin
          w_state_next = c_OVER;
        end
      end
      c_OVER: begin
        if (!bus.enable) begin
          w_state_next = c_IDLE;
        end
      end
      default: begin
        w_state_next = c_IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- FSM controls
  // w_advance excludes the collision cycle, so a coincident tick is dropped.
  always_comb begin
    w_start   = 1'b0;
    w_clear   = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_start = (w_state_next == c_RUN);
      end
      c_RUN: begin
        w_clear   = (w_state_next == c_IDLE);
        w_advance = (w_state_next == c_RUN);
      end
      c_OVER: begin
        w_clear = (w_state_next == c_IDLE);
      end
      default: begin
        w_clear = 1'b1;
      end
    endcase
  end

  assign w_tick = w_advance && (r_tick_cnt == c_TICK_LAST);

  // Gap row taken from the pre-shift LFSR, clamped so the 3-row gap fits.
  assign w_gap     = (r_lfsr[2:0] > c_GAP_MAX) ? c_GAP_MAX : r_lfsr[2:0];
  assign w_pipe    = ~(8'b0000_0111 << w_gap);
  assign w_new_col = (r_spc_cnt == '0) ? w_pipe : 8'h00;
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      r_red_array <= '0;
      r_score     <= 8'h00;
      r_game_over <= 1'b0;
      r_tick_cnt  <= '0;
      r_spc_cnt   <= '0;
      r_lfsr      <= c_LFSR_SEED;
    end else begin
      r_game_over <= (w_state_next == c_OVER);

      if (w_start) begin
        r_score    <= 8'h00;
        r_tick_cnt <= '0;
        r_spc_cnt  <= '0;
      end

      if (w_clear) begin
        r_red_array <= '0;
      end

      if (w_advance) begin
        if (w_tick) begin
          r_tick_cnt  <= '0;
          r_red_array <= {w_new_col, r_red_array[7:1]};
          r_lfsr      <= {r_lfsr[6:0], w_lfsr_fb};
          r_spc_cnt   <= (r_spc_cnt == c_SPC_LAST) ? '0 : r_spc_cnt + 1'b1;
          if ((r_red_array[0] != 8'h00) && (r_score != 8'hFF)) begin
            r_score <= r_score + 8'd1;
          end
        end else begin
          r_tick_cnt <= r_tick_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.red_array = r_red_array;
  assign bus.game_over = r_game_over;
  assign bus.score     = r_score;

endmodule
`default_nettype wire

// File: tb/tb_pipe_engine.sv
`default_nettype none
// ============================================================================
// tb_pipe_engine
//   Directed scoreboard bench for pipe_engine with SCROLL_PERIOD=4,
//   PIPE_SPACING=4; expected playfield values are hand-derived from the LFSR.
//   Rev 1.0 - initial release
// ============================================================================
module tb_pipe_engine;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  pipe_engine_if bus ();

  pipe_engine #(
    .SCROLL_PERIOD (4),
    .PIPE_SPACING  (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [63:0] red;
    logic [7:0]  score;
    logic        go;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [63:0] r,
                            input logic [7:0] s, input logic g);
    sb.push_back('{cyc, nm, r, s, g});
  endtask

  // Monitor: compares each queued expectation on the cycle it was tagged with.
  always @(negedge clock) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)",
                 mon_e.name, mon_e.cyc, cyc);
      end else begin
        n_checks++;
        if (bus.red_array !== mon_e.red) begin
          n_fail++;
          $display("FAIL %s red_array: got %h expected %h",
                   mon_e.name, bus.red_array, mon_e.red);
        end
        n_checks++;
        if (bus.score !== mon_e.score) begin
          n_fail++;
          $display("FAIL %s score: got %0d expected %0d",
                   mon_e.name, bus.score, mon_e.score);
        end
        n_checks++;
        if (bus.game_over !== mon_e.go) begin
          n_fail++;
          $display("FAIL %s game_over: got %b expected %b",
                   mon_e.name, bus.game_over, mon_e.go);
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.enable   = 1'b1;
    bus.bird_row = 8'h08;
    reset        = 1'b1;

    // Game 1: reset with enable high, first pipe, then collision at column 0.
    edges(2);  expect_out("reset",       64'h0, 8'd0, 1'b0);
    reset = 1'b0;
    edges(1);  expect_out("idle_to_run", 64'h0, 8'd0, 1'b0);
    edges(3);  expect_out("pre_tick1",   64'h0, 8'd0, 1'b0);
    edges(1);  expect_out("tick1",       64'h1F00_0000_0000_0000, 8'd0, 1'b0);
    edges(4);  expect_out("tick2",       64'h001F_0000_0000_0000, 8'd0, 1'b0);
    edges(12); expect_out("tick5",       64'h8F00_0000_1F00_0000, 8'd0, 1'b0);
    edges(12); expect_out("tick8",       64'h0000_008F_0000_001F, 8'd0, 1'b0);
    edges(1);  expect_out("collide",     64'h0000_008F_0000_001F, 8'd0, 1'b1);
    edges(8);  expect_out("over_hold",   64'h0000_008F_0000_001F, 8'd0, 1'b1);

    // Reset pulse in OVER restores the seed; bird flies through the gaps.
    reset = 1'b1;
    edges(1);  expect_out("reset_over",  64'h0, 8'd0, 1'b0);
    reset        = 1'b0;
    bus.bird_row = 8'h40;
    edges(1);  expect_out("replay_start", 64'h0, 8'd0, 1'b0);
    edges(4);  expect_out("replay_tick1", 64'h1F00_0000_0000_0000, 8'd0, 1'b0);
    edges(28); expect_out("pass_tick8",   64'h0000_008F_0000_001F, 8'd0, 1'b0);
    edges(3);  expect_out("pass_pre9",    64'h0000_008F_0000_001F, 8'd0, 1'b0);
    edges(1);  expect_out("pass_tick9",   64'h1F00_0000_8F00_0000, 8'd1, 1'b0);
    edges(12); expect_out("pass_tick12",  64'h0000_001F_0000_008F, 8'd1, 1'b0);
    edges(4);  expect_out("pass_tick13",  64'h1F00_0000_1F00_0000, 8'd2, 1'b0);

    // Stop mid-run, then restart; LFSR continues from where it stopped.
    bus.enable = 1'b0;
    edges(1);  expect_out("stop",        64'h0, 8'd2, 1'b0);
    edges(1);  expect_out("idle_hold",   64'h0, 8'd2, 1'b0);
    bus.enable   = 1'b1;
    bus.bird_row = 8'hC0;
    edges(1);  expect_out("restart",       64'h0, 8'd0, 1'b0);
    edges(4);  expect_out("restart_tick1", 64'h1F00_0000_0000_0000, 8'd0, 1'b0);
    edges(28); expect_out("restart_tick8", 64'h0000_00F1_0000_001F, 8'd0, 1'b0);

    // Non-one-hot bird row overlapping a single pipe row still collides.
    bus.bird_row = 8'h21;
    edges(1);  expect_out("nonhot_collide", 64'h0000_00F1_0000_001F, 8'd0, 1'b1);
    bus.enable = 1'b0;
    edges(1);  expect_out("over_to_idle",   64'h0, 8'd0, 1'b0);
    edges(2);  expect_out("idle_overlap",   64'h0, 8'd0, 1'b0);

    edges(2);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
